// File: rtl/online_to_binary_conv_if.sv
// Handshake bundle for online_to_binary_conv.
//   din/in_valid/in_ready    : redundant-digit input word, valid/ready
//   dout/out_valid/out_ready : two's complement result, valid/ready
//   ovf                      : result did not fit in OUT_W (saturating build only)
// slave is the converter side, master is the producer/consumer side.
interface online_to_binary_conv_if #(
  parameter int unsigned Stage = 18,
  parameter int unsigned OUT_W = 19
);
  logic [2*Stage-1:0] din;
  logic               in_valid;
  logic               in_ready;
  logic [OUT_W-1:0]   dout;
  logic               out_valid;
  logic               out_ready;
  logic               ovf;

  modport slave (
    input  din, in_valid, out_ready,
    output in_ready, dout, out_valid, ovf
  );

  modport master (
    output din, in_valid, out_ready,
    input  in_ready, dout, out_valid, ovf
  );
endinterface

// File: rtl/online_to_binary_conv.sv
// online_to_binary_conv: MSB-first signed-digit to two's complement converter.
// Consumes one {p,n} digit per clock using on-the-fly conversion (Q / QM = Q - 1 registers).
// Ports:
//   clk, rst : clock and asynchronous active-high reset
//   enable   : low aborts to idle on the next edge, clearing conversion state
//   busy     : converter not idle
//   bus      : online_to_binary_conv_if.slave (din/in_valid/in_ready, dout/out_valid/out_ready, ovf)
// Build option ONLINE_CONV_SAT_EN: saturate dout and raise ovf when the result does not fit
// in OUT_W bits; otherwise dout is the wrapped/sign-extended result and ovf is 0.
module online_to_binary_conv #(
  parameter int unsigned Stage = 18,
  parameter int unsigned OUT_W = 19
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enable,
  output logic                   busy,
  online_to_binary_conv_if.slave bus
);

  localparam int unsigned SW = 2 * Stage;
  localparam int unsigned QW = Stage + 1;
  localparam int unsigned CW = (Stage > 1) ? $clog2(Stage) : 1;

  typedef enum logic [1:0] {StIdle, StConv, StDone} state_e;

  state_e          state_q, state_d;
  logic [SW-1:0]   sr_q, sr_d;
  logic [QW-1:0]   q_q, q_d, qm_q, qm_d;
  logic [QW-1:0]   q_nxt, qm_nxt;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [OUT_W-1:0] dout_q, dout_d, res_dout;
  logic            ovf_q, ovf_d, res_ovf;
  logic [1:0]      digit;
  logic            in_ready;
  logic            last_digit;

  assign digit      = sr_q[SW-1 -: 2];
  assign last_digit = (cnt_q == CW'(Stage - 1));

  // On-the-fly append of the current digit; the top bit shifts out each step.
  always_comb begin
    q_nxt  = q_q;
    qm_nxt = qm_q;
    unique case (digit)
      2'b10: begin
        q_nxt  = QW'({q_q, 1'b1});
        qm_nxt = QW'({q_q, 1'b0});
      end
      2'b01: begin
        q_nxt  = QW'({qm_q, 1'b1});
        qm_nxt = QW'({qm_q, 1'b0});
      end
      default: begin
        q_nxt  = QW'({q_q, 1'b0});
        qm_nxt = QW'({qm_q, 1'b1});
      end
    endcase
  end

`ifdef ONLINE_CONV_SAT_EN
  localparam int unsigned XW = (OUT_W > QW) ? OUT_W : QW;
  logic [XW-1:0]       q_ext;
  logic [XW-OUT_W:0]   q_hi;

  // Fits iff every bit above the OUT_W sign bit equals the sign bit.
  always_comb begin
    q_ext   = XW'($signed(q_nxt));
    q_hi    = q_ext[XW-1:OUT_W-1];
    res_ovf = !((&q_hi) || !(|q_hi));
    if (res_ovf) begin
      res_dout = {q_ext[XW-1], {(OUT_W-1){~q_ext[XW-1]}}};
    end else begin
      res_dout = q_ext[OUT_W-1:0];
    end
  end
`else
  always_comb begin
    res_dout = OUT_W'($signed(q_nxt));
    res_ovf  = 1'b0;
  end
`endif

  // FSM: state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (bus.in_valid && in_ready) state_d = StConv;
      StConv: if (last_digit) state_d = StDone;
      StDone: if (bus.out_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
    if (!enable) state_d = StIdle;
  end

  // FSM: outputs
  always_comb begin
    in_ready      = (state_q == StIdle) && enable && !rst;
    bus.in_ready  = in_ready;
    bus.out_valid = (state_q == StDone);
    busy          = (state_q != StIdle);
    bus.dout      = dout_q;
    bus.ovf       = ovf_q;
  end

  // Datapath next state
  always_comb begin
    sr_d   = sr_q;
    q_d    = q_q;
    qm_d   = qm_q;
    cnt_d  = cnt_q;
    dout_d = dout_q;
    ovf_d  = ovf_q;
    if (!enable) begin
      // Abort: conversion state cleared, last result left on dout.
      sr_d  = '0;
      q_d   = '0;
      qm_d  = '1;
      cnt_d = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.in_valid && in_ready) begin
            sr_d  = bus.din;
            q_d   = '0;
            qm_d  = '1;
            cnt_d = '0;
          end
        end
        StConv: begin
          sr_d  = {sr_q[SW-3:0], 2'b00};
          q_d   = q_nxt;
          qm_d  = qm_nxt;
          cnt_d = cnt_q + CW'(1);
          if (last_digit) begin
            dout_d = res_dout;
            ovf_d  = res_ovf;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr_q   <= '0;
      q_q    <= '0;
      qm_q   <= '1;
      cnt_q  <= '0;
      dout_q <= '0;
      ovf_q  <= 1'b0;
    end else begin
      sr_q   <= sr_d;
      q_q    <= q_d;
      qm_q   <= qm_d;
      cnt_q  <= cnt_d;
      dout_q <= dout_d;
      ovf_q  <= ovf_d;
    end
  end

endmodule
